// File: rtl/if_id_redirect_unit_pkg.sv
// Shared constants, types and decode helpers for the IF/ID redirect unit.
// The constants are the MIPS opcode and funct encodings that the ID stage resolves.
package if_id_redirect_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Byte step that fetch adds to the PC after it takes a redirect.
    localparam int unsigned PC_STEP_DEFAULT = 4;

    // Control-flow class of the instruction held in IF/ID.
    typedef enum logic [2:0] {
        CF_NONE,
        CF_BEQ,
        CF_BNE,
        CF_J,
        CF_JAL,
        CF_JR
    } cf_kind_e;

    // Classify an instruction word by its control-flow behaviour.
    function automatic cf_kind_e decode_cf(input logic [31:0] instr);
        cf_kind_e kind;
        kind = CF_NONE;
        case (instr[31:26])
            OP_BEQ:   kind = CF_BEQ;
            OP_BNE:   kind = CF_BNE;
            OP_J:     kind = CF_J;
            OP_JAL:   kind = CF_JAL;
            OP_RTYPE: if (instr[5:0] == FUNCT_JR) kind = CF_JR;
            default:  kind = CF_NONE;
        endcase
        return kind;
    endfunction

    // True when the instruction reads its rt field as a source operand.
    function automatic logic uses_rt(input logic [31:0] instr);
        return (instr[31:26] == OP_RTYPE) || (instr[31:26] == OP_BEQ) ||
               (instr[31:26] == OP_BNE);
    endfunction

endpackage

// File: rtl/if_id_redirect_unit_if.sv
// Fetch-side interface: the instruction/PC pair delivered by fetch and the
// redirect and hold controls returned to it.
interface if_id_redirect_unit_if;

    logic [31:0] ReadData;
    logic [31:0] PCAddress;
    logic        PCSrc;
    logic [31:0] InputAddress;
    logic        stallDetector;

    // Fetch stage: supplies instructions, obeys redirect and hold.
    modport master (
        output ReadData,
        output PCAddress,
        input  PCSrc,
        input  InputAddress,
        input  stallDetector
    );

    // IF/ID consumer: latches instructions, drives redirect and hold.
    modport slave (
        input  ReadData,
        input  PCAddress,
        output PCSrc,
        output InputAddress,
        output stallDetector
    );

endinterface

// File: rtl/if_id_redirect_unit_redirect_resolve.sv
// Combinational control-flow resolution for the instruction held in IF/ID.
// Produces whether the instruction redirects and its absolute target address.
module if_id_redirect_unit_redirect_resolve
    import if_id_redirect_unit_pkg::*;
(
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc4,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        taken,
    output logic [31:0] target
);

    cf_kind_e    kind;
    logic        eq;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign kind          = decode_cf(id_instr);
    assign eq            = (rs_data == rt_data);
    assign branch_target = id_pc4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
    assign jump_target   = {id_pc4[31:28], id_instr[25:0], 2'b00};

    // Select taken/target by control-flow class.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        taken  = 1'b0;
        target = id_pc4;
        case (kind)
            CF_BEQ: begin
                taken  = eq;
                target = branch_target;
            end
            CF_BNE: begin
                taken  = !eq;
                target = branch_target;
            end
            CF_J, CF_JAL: begin
                taken  = 1'b1;
                target = jump_target;
            end
            CF_JR: begin
                taken  = 1'b1;
                target = rs_data;
            end
            default: begin
                taken  = 1'b0;
                target = id_pc4;
            end
        endcase
    end

endmodule

// File: rtl/if_id_redirect_unit.sv
// IF/ID register with ID-stage control-flow resolution and hazard detection.
// Holds the pipeline on load-use and branch-operand hazards, redirects fetch
// on taken control flow (squashing the wrong-path fetch), and keeps
// saturating counts of stall cycles and redirects.
module if_id_redirect_unit
    import if_id_redirect_unit_pkg::*;
#(
    parameter int unsigned PC_STEP = PC_STEP_DEFAULT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    if_id_redirect_unit_if.slave fetch,
    input  logic [31:0]          rs_data,
    input  logic [31:0]          rt_data,
    input  logic                 ex_mem_read,
    input  logic                 ex_reg_write,
    input  logic [4:0]           ex_dst,
    input  logic                 mem_mem_read,
    input  logic [4:0]           mem_dst,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc4,
    output logic                 id_valid,
    output logic [4:0]           id_rs,
    output logic [4:0]           id_rt,
    output logic                 bubble,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     redirect_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    cf_kind_e    kind;
    logic        id_uses_rt;
    logic        is_branch_src;
    logic        rt_is_src;
    logic        load_use;
    logic        branch_hazard;
    logic        stall;
    logic        redirect;
    logic        taken;
    logic [31:0] target;

    assign id_rs = id_instr[25:21];
    assign id_rt = id_instr[20:16];

    assign kind          = decode_cf(id_instr);
    assign id_uses_rt    = uses_rt(id_instr);
    assign is_branch_src = (kind == CF_BEQ) || (kind == CF_BNE) || (kind == CF_JR);
    assign rt_is_src     = (kind == CF_BEQ) || (kind == CF_BNE);

    if_id_redirect_unit_redirect_resolve u_resolve (
        .id_instr (id_instr),
        .id_pc4   (id_pc4),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .taken    (taken),
        .target   (target)
    );

    // Hazard detection: a load in EX feeding ID, or a branch/jr operand still in flight.
    always_comb begin
        load_use      = 1'b0;
        branch_hazard = 1'b0;
        if (ex_mem_read && (ex_dst != 5'd0)) begin
            load_use = (ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt));
        end
        if (is_branch_src) begin
            if (ex_reg_write && (ex_dst != 5'd0) &&
                ((ex_dst == id_rs) || (rt_is_src && (ex_dst == id_rt)))) begin
                branch_hazard = 1'b1;
            end
            if (mem_mem_read && (mem_dst != 5'd0) &&
                ((mem_dst == id_rs) || (rt_is_src && (mem_dst == id_rt)))) begin
                branch_hazard = 1'b1;
            end
        end
    end

    assign stall    = id_valid && (load_use || branch_hazard);
    assign redirect = id_valid && !stall && taken;

    // Fetch-side controls; the redirect address is pre-compensated for fetch's own PC step.
    always_comb begin
        fetch.PCSrc         = redirect;
        fetch.stallDetector = !stall;
        fetch.InputAddress  = 32'h0;
        bubble              = stall;
        if (id_valid) begin
            fetch.InputAddress = target - 32'(PC_STEP);
        end
    end

    // IF/ID register: reset, then hold on stall, squash on redirect, else latch fetch.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (Rst) begin
            id_instr <= NOP_WORD;
            id_pc4   <= 32'h0;
            id_valid <= 1'b0;
        end else if (stall) begin
            id_instr <= id_instr;
            id_pc4   <= id_pc4;
            id_valid <= id_valid;
        end else if (redirect) begin
            id_instr <= NOP_WORD;
            id_pc4   <= fetch.PCAddress + 32'd4;
            id_valid <= 1'b0;
        end else begin
            id_instr <= fetch.ReadData;
            id_pc4   <= fetch.PCAddress + 32'd4;
            id_valid <= 1'b1;
        end
    end

    // Saturating stall and redirect counters.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (redirect && (redirect_cnt != CNT_MAX)) begin
                redirect_cnt <= redirect_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_id_redirect_unit.sv
// Directed self-checking bench for if_id_redirect_unit. A second instance with
// a 4-bit counter width shares the stimulus so counter saturation is reachable
// in a short run.
module tb_if_id_redirect_unit;

    localparam logic [31:0] I_ADD  = 32'h0133_5020; // add $t2,$t1,$s3
    localparam logic [31:0] I_BEQ  = 32'h112A_0001; // beq $t1,$t2,+1
    localparam logic [31:0] I_JR   = 32'h01A0_0008; // jr  $t5
    localparam logic [31:0] I_J    = 32'h0800_0013; // j   0x13
    localparam logic [31:0] I_JAL  = 32'h0C00_0013; // jal 0x13
    localparam logic [31:0] I_JUNK = 32'hDEAD_BEEF;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] rs_data, rt_data;
    logic        ex_mem_read, ex_reg_write, mem_mem_read;
    logic [4:0]  ex_dst, mem_dst;

    logic [31:0] id_instr, id_pc4;
    logic        id_valid, bubble;
    logic [4:0]  id_rs, id_rt;
    logic [15:0] stall_cnt, redirect_cnt;

    logic [31:0] sat_id_instr, sat_id_pc4;
    logic        sat_id_valid, sat_bubble;
    logic [4:0]  sat_id_rs, sat_id_rt;
    logic [3:0]  sat_stall_cnt, sat_redirect_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    if_id_redirect_unit_if fetch_if ();
    if_id_redirect_unit_if sat_if ();

    assign sat_if.ReadData  = fetch_if.ReadData;
    assign sat_if.PCAddress = fetch_if.PCAddress;

    if_id_redirect_unit #(.PC_STEP(4), .CNT_W(16)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .fetch        (fetch_if),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_dst       (ex_dst),
        .mem_mem_read (mem_mem_read),
        .mem_dst      (mem_dst),
        .id_instr     (id_instr),
        .id_pc4       (id_pc4),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .bubble       (bubble),
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
    );

    if_id_redirect_unit #(.PC_STEP(4), .CNT_W(4)) dut_sat (
        .Clk          (Clk),
        .Rst          (Rst),
        .fetch        (sat_if),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_dst       (ex_dst),
        .mem_mem_read (mem_mem_read),
        .mem_dst      (mem_dst),
        .id_instr     (sat_id_instr),
        .id_pc4       (sat_id_pc4),
        .id_valid     (sat_id_valid),
        .id_rs        (sat_id_rs),
        .id_rt        (sat_id_rt),
        .bubble       (sat_bubble),
        .stall_cnt    (sat_stall_cnt),
        .redirect_cnt (sat_redirect_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 2 ns past the edge, away from it.
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        fetch_if.ReadData  = $urandom;
        fetch_if.PCAddress = 32'h0;
        rs_data      = 32'h0;
        rt_data      = 32'h0;
        ex_mem_read  = 1'b0;
        ex_reg_write = 1'b0;
        ex_dst       = 5'd0;
        mem_mem_read = 1'b0;
        mem_dst      = 5'd0;

        // Reset for two cycles with random fetch data.
        tick();
        fetch_if.ReadData = $urandom;
        tick();
        check("rst_instr",    id_instr, 32'h0);
        check("rst_valid",    32'(id_valid), 32'h0);
        check("rst_pcsrc",    32'(fetch_if.PCSrc), 32'h0);
        check("rst_stalldet", 32'(fetch_if.stallDetector), 32'h1);
        check("rst_bubble",   32'(bubble), 32'h0);
        check("rst_inaddr",   fetch_if.InputAddress, 32'h0);
        check("rst_stallcnt", 32'(stall_cnt), 32'h0);
        check("rst_redircnt", 32'(redirect_cnt), 32'h0);

        // Load add into IF/ID.
        Rst = 1'b0;
        fetch_if.ReadData  = I_ADD;
        fetch_if.PCAddress = 32'h0;
        tick();
        check("add_instr", id_instr, I_ADD);
        check("add_pc4",   id_pc4, 32'h4);
        check("add_valid", 32'(id_valid), 32'h1);

        // Load-use on rs.
        ex_mem_read = 1'b1;
        ex_dst      = 5'd9;
        fetch_if.ReadData = 32'hAAAA_0000;
        #1;
        check("lu_stalldet", 32'(fetch_if.stallDetector), 32'h0);
        check("lu_bubble",   32'(bubble), 32'h1);
        check("lu_pcsrc",    32'(fetch_if.PCSrc), 32'h0);
        tick();
        check("lu_hold",     id_instr, I_ADD);
        check("lu_stallcnt", 32'(stall_cnt), 32'h1);
        ex_mem_read = 1'b0;
        #1;
        check("lu_release", 32'(fetch_if.stallDetector), 32'h1);
        check("lu_nobubble", 32'(bubble), 32'h0);
        // Load-use on rt of an R-type, then register 0 never hazards.
        ex_mem_read = 1'b1;
        ex_dst      = 5'd19;
        #1;
        check("lu_rt_stall", 32'(fetch_if.stallDetector), 32'h0);
        ex_dst = 5'd0;
        #1;
        check("lu_r0_nostall", 32'(fetch_if.stallDetector), 32'h1);
        ex_mem_read = 1'b0;

        // beq at PC 8.
        fetch_if.ReadData  = I_BEQ;
        fetch_if.PCAddress = 32'h8;
        tick();
        check("beq_pc4", id_pc4, 32'hC);
        rs_data = 32'd5;
        rt_data = 32'd6;
        #1;
        check("beq_ne_pcsrc", 32'(fetch_if.PCSrc), 32'h0);
        rt_data = 32'd5;
        #1;
        check("beq_eq_pcsrc",  32'(fetch_if.PCSrc), 32'h1);
        check("beq_eq_inaddr", fetch_if.InputAddress, 32'hC);
        fetch_if.ReadData  = I_JUNK;
        fetch_if.PCAddress = 32'hC;
        tick();
        check("beq_squash_valid", 32'(id_valid), 32'h0);
        check("beq_squash_instr", id_instr, 32'h0);
        check("beq_redircnt",     32'(redirect_cnt), 32'h1);
        #1;
        check("squash_pcsrc", 32'(fetch_if.PCSrc), 32'h0);

        // Not-taken beq falls through to a sequential latch.
        fetch_if.ReadData  = I_BEQ;
        fetch_if.PCAddress = 32'h8;
        tick();
        rt_data = 32'd6;
        fetch_if.ReadData  = I_ADD;
        fetch_if.PCAddress = 32'hC;
        tick();
        check("nt_seq_instr", id_instr, I_ADD);
        check("nt_seq_pc4",   id_pc4, 32'h10);
        check("nt_redircnt",  32'(redirect_cnt), 32'h1);

        // Branch-operand hazards on beq.
        rt_data = 32'd5;
        fetch_if.ReadData  = I_BEQ;
        fetch_if.PCAddress = 32'h8;
        tick();
        ex_reg_write = 1'b1;
        ex_dst       = 5'd9;
        #1;
        check("bh_ex_stall",  32'(fetch_if.stallDetector), 32'h0);
        check("bh_ex_bubble", 32'(bubble), 32'h1);
        check("bh_ex_pcsrc",  32'(fetch_if.PCSrc), 32'h0);
        fetch_if.ReadData = I_JUNK;
        tick();
        check("bh_hold",     id_instr, I_BEQ);
        check("bh_stallcnt", 32'(stall_cnt), 32'h2);
        ex_reg_write = 1'b0;
        #1;
        check("bh_resolve", 32'(fetch_if.PCSrc), 32'h1);
        mem_mem_read = 1'b1;
        mem_dst      = 5'd10;
        #1;
        check("bh_mem_stall", 32'(fetch_if.stallDetector), 32'h0);
        check("bh_mem_pcsrc", 32'(fetch_if.PCSrc), 32'h0);
        mem_dst = 5'd0;
        #1;
        check("bh_mem_r0", 32'(fetch_if.stallDetector), 32'h1);
        mem_mem_read = 1'b0;
        ex_reg_write = 1'b1;
        ex_dst       = 5'd0;
        #1;
        check("bh_ex_r0_stalldet", 32'(fetch_if.stallDetector), 32'h1);
        check("bh_ex_r0_pcsrc",    32'(fetch_if.PCSrc), 32'h1);
        ex_reg_write = 1'b0;
        tick();
        check("bh_redircnt", 32'(redirect_cnt), 32'h2);
        check("bh_squash",   32'(id_valid), 32'h0);

        // jr $t5 to 0x50.
        fetch_if.ReadData  = I_JR;
        fetch_if.PCAddress = 32'h30;
        tick();
        rs_data = 32'h50;
        #1;
        check("jr_pcsrc",  32'(fetch_if.PCSrc), 32'h1);
        check("jr_inaddr", fetch_if.InputAddress, 32'h4C);
        ex_reg_write = 1'b1;
        ex_dst       = 5'd13;
        #1;
        check("jr_bh_stall", 32'(fetch_if.stallDetector), 32'h0);
        check("jr_bh_pcsrc", 32'(fetch_if.PCSrc), 32'h0);
        ex_reg_write = 1'b0;
        ex_dst       = 5'd0;
        tick();
        check("jr_redircnt", 32'(redirect_cnt), 32'h3);

        // j 0x13 with id_pc4 = 8.
        fetch_if.ReadData  = I_J;
        fetch_if.PCAddress = 32'h4;
        tick();
        #1;
        check("j_pcsrc",  32'(fetch_if.PCSrc), 32'h1);
        check("j_inaddr", fetch_if.InputAddress, 32'h48);
        tick();
        check("j_redircnt", 32'(redirect_cnt), 32'h4);

        // jal 0x13 at PC 0x20: link value stays in id_pc4.
        fetch_if.ReadData  = I_JAL;
        fetch_if.PCAddress = 32'h20;
        tick();
        #1;
        check("jal_pcsrc",  32'(fetch_if.PCSrc), 32'h1);
        check("jal_inaddr", fetch_if.InputAddress, 32'h48);
        check("jal_link",   id_pc4, 32'h24);
        tick();
        check("jal_redircnt", 32'(redirect_cnt), 32'h5);

        // Reset during an active stall.
        fetch_if.ReadData  = I_ADD;
        fetch_if.PCAddress = 32'h40;
        tick();
        ex_mem_read = 1'b1;
        ex_dst      = 5'd9;
        tick();
        check("pre_rst_stallcnt",     32'(stall_cnt), 32'h3);
        check("pre_rst_sat_stallcnt", 32'(sat_stall_cnt), 32'h3);
        Rst = 1'b1;
        tick();
        check("mid_rst_valid",    32'(id_valid), 32'h0);
        check("mid_rst_instr",    id_instr, 32'h0);
        check("mid_rst_stallcnt", 32'(stall_cnt), 32'h0);
        check("mid_rst_redircnt", 32'(redirect_cnt), 32'h0);
        check("mid_rst_stalldet", 32'(fetch_if.stallDetector), 32'h1);

        // Long stall: the narrow instance saturates, the wide one keeps counting.
        Rst = 1'b0;
        tick();
        check("sat_load_instr", id_instr, I_ADD);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("long_stallcnt",    32'(stall_cnt), 32'd20);
        check("sat_stallcnt",     32'(sat_stall_cnt), 32'hF);
        check("sat_redircnt",     32'(sat_redirect_cnt), 32'h0);
        check("sat_hold_instr",   sat_id_instr, I_ADD);
        ex_mem_read = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_id_redirect_unit.md
Name: if_id_redirect_unit

Overview:
Consumer end of the fetch interface. It latches the fetched instruction and its PC into the IF/ID register and resolves control flow (beq, bne, j, jal, jr) in ID. It detects load-use and branch-operand hazards and drives the fetch-side controls: PCSrc, InputAddress and stallDetector (0 = stall). It also flushes wrong-path instructions and keeps saturating stall and redirect counters.

Parameters:
PC_STEP, 4, byte increment applied by fetch (the PC loads InputAddress+PC_STEP on redirect).
CNT_W, 16, width of the stall and redirect counters.

Ports:
Clk  in  1  clock; all state updates on posedge.
Rst  in  1  synchronous, active-high reset.
ReadData  in  32  instruction from fetch, valid at posedge.
PCAddress  in  32  fetch OutputAddress; the PC of ReadData.
rs_data  in  32  register-file value for id_rs.
rt_data  in  32  register-file value for id_rt.
ex_mem_read  in  1  instruction in EX is a load.
ex_reg_write  in  1  instruction in EX writes a register.
ex_dst  in  5  destination register of the EX instruction.
mem_mem_read  in  1  instruction in MEM is a load.
mem_dst  in  5  destination register of the MEM instruction.
id_instr  out  32  IF/ID instruction; 0 = nop.
id_pc4  out  32  IF/ID PC+4; also the jal link value.
id_valid  out  1  IF/ID holds a real instruction.
id_rs  out  5  id_instr[25:21].
id_rt  out  5  id_instr[20:16].
PCSrc  out  1  redirect fetch this cycle.
InputAddress  out  32  redirect address = target − PC_STEP.
stallDetector  out  1  0 = hold PC and IF/ID.
bubble  out  1  insert a nop into ID/EX.
stall_cnt  out  CNT_W  saturating count of stall cycles.
redirect_cnt  out  CNT_W  saturating count of redirects.

Behaviour:
- Reset (synchronous, Rst=1 at posedge): id_instr=0, id_pc4=0, id_valid=0, stall_cnt=0, redirect_cnt=0.
- Combinational outputs while id_valid=0: PCSrc=0, stallDetector=1, bubble=0, InputAddress=0.
- Decode of id_instr:
  - opcode [31:26]: beq=000100, bne=000101, j=000010, jal=000011.
  - jr: opcode 0 with funct [5:0]=001000.
  - uses_rt: R-type, beq and bne.
- Load-use hazard (lu):
  - ex_mem_read=1, ex_dst≠0, and (ex_dst==id_rs, or ex_dst==id_rt with uses_rt).
- Branch hazard (bh), only when the ID instruction is beq, bne or jr:
  - ex_reg_write=1 and ex_dst≠0 and ex_dst matches a source register, or
  - mem_mem_read=1 and mem_dst≠0 and mem_dst matches a source register.
- stall = id_valid & (lu | bh). Then stallDetector=0 and bubble=1; otherwise stallDetector=1 and bubble=0.
- Resolution is combinational and only happens when there is no stall. eq = (rs_data==rt_data).
  - taken = beq&eq | bne&!eq | j | jal | jr.
  - Branch target: id_pc4 + (sign-extended imm[15:0] << 2).
  - j/jal target: {id_pc4[31:28], id_instr[25:0], 2'b00}.
  - jr target: rs_data.
  - PCSrc = id_valid & !stall & taken.
  - InputAddress = target − PC_STEP, computed modulo 2^32, so that fetch lands exactly on target.
- IF/ID update at posedge, priority Rst > stall > redirect > normal:
  - stall: hold all IF/ID fields.
  - redirect (PCSrc=1): load id_instr=0 and id_valid=0, squashing the wrong-path ReadData; id_pc4 takes PCAddress+4 (don't-care).
  - normal: id_instr=ReadData, id_pc4=PCAddress+4, id_valid=1.
- Redirect penalty is exactly 1 cycle. The target instruction appears in IF/ID on the second posedge after the redirect.
- Counters:
  - stall_cnt increments on each posedge with stall=1.
  - redirect_cnt increments on each posedge with PCSrc=1.
  - Both saturate at 2^CNT_W−1 (no wrap).
- Register 0 never causes a hazard. Stall and redirect are mutually exclusive by construction.
- Rst asserted mid-stall or mid-redirect clears everything at that edge; nothing pending survives.

Decomposition:
- Shared package holds:
  - opcode and funct constants: OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_JAL, FUNCT_JR, OP_LW.
  - the NOP word (32'h0).
  - the PC_STEP default.
- One sub-module: redirect_resolve. Purely combinational; takes id_instr, id_pc4, rs_data and rt_data; produces taken and target.
- Hazard detection, the IF/ID register and the counters stay in the top module.

Test Plan:
1. Rst=1 for 2 cycles with random ReadData -> id_instr=0, id_valid=0, PCSrc=0, stallDetector=1, bubble=0, both counters 0.
2. ID holds add $t2,$t1,$s3; ex_mem_read=1, ex_dst=9 for 1 cycle -> stallDetector=0, bubble=1, id_instr held. Next cycle (ex_mem_read=0) stall released; stall_cnt=1.
3. beq $t1,$t2,+1 at PCAddress 8 (id_pc4=12), rs_data=rt_data=5 -> PCSrc=1, InputAddress=12 (target 16). Next edge: id_valid=0, id_instr=0, redirect_cnt=1. With rt_data=6 instead -> PCSrc=0 and sequential latch.
4. Same beq with ex_reg_write=1, ex_dst=9 -> 1 stall cycle, then resolve. Separately mem_mem_read=1, mem_dst=10 -> stall. Repeat with ex_dst=0 -> no stall.
5. jr $t5 with rs_data=0x50 -> InputAddress=0x4C. j index 0x13 with id_pc4=8 -> target 0x4C, InputAddress=0x48. jal: id_pc4 unchanged as link.
6. Rst asserted during an active stall -> cleared at that edge. Also force stall_cnt to max and stall again -> value holds at 0xFFFF.
